source_wakeup_cam: RTL and testbench
====================================

SOURCE_WAKEUP_CAM -- requirements
Module: source_wakeup_cam

Interface
REQ-001 Parameter ENTRY_NUM, default 16, number of issue-queue entries.
REQ-002 Parameter SRC_OP_NUM, default 2, source operands per entry.
REQ-003 Parameter REG_NUM_BIT_WIDTH, default 7, physical register tag width.
REQ-004 Parameter DISPATCH_WIDTH, default 2, dispatch lanes.
REQ-005 Parameter WAKEUP_WIDTH, default 4, wakeup broadcast lanes.
REQ-006 Parameter LAT_WIDTH, default 3, wakeup latency field width.
REQ-007 Parameter STALL_GATED_MASK, default 4'b0011, WAKEUP_WIDTH bits; set bit = lane ignored while stall high.
REQ-008 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-009 stall  in  1  pipeline stall, gates lanes selected by STALL_GATED_MASK.
REQ-010 dispatch  in  [DISPATCH_WIDTH]x1  per-lane write enable.
REQ-011 dispatchPtr  in  [DISPATCH_WIDTH]x clog2(ENTRY_NUM)  target entry.
REQ-012 dispatchedSrcRegNum  in  [DISPATCH_WIDTH][SRC_OP_NUM]x REG_NUM_BIT_WIDTH  source tags.
REQ-013 dispatchedSrcReady  in  [DISPATCH_WIDTH][SRC_OP_NUM]x1  source already ready/invalid.
REQ-014 wakeup, wakeupDstValid  in  [WAKEUP_WIDTH]x1  broadcast valid qualifiers (both required).
REQ-015 wakeupDstRegNum  in  [WAKEUP_WIDTH]x REG_NUM_BIT_WIDTH  broadcast tag.
REQ-016 wakeupLatency  in  [WAKEUP_WIDTH]x LAT_WIDTH  cycles until producer result available.
REQ-017 wakeupSpec  in  [WAKEUP_WIDTH]x1  broadcast depends on unresolved load hit.
REQ-018 specConfirm, specCancel  in  1 each  load-speculation resolution pulses.
REQ-019 flush  in  ENTRY_NUM  per-entry invalidate.
REQ-020 opReady  out  ENTRY_NUM  entry valid and all sources ready.
REQ-021 opSpecReady  out  ENTRY_NUM  opReady and at least one source ready via spec wakeup.

Function
REQ-022 Per source state: WAIT, COUNT(cnt), READY, plus spec bit; per entry valid bit.
REQ-023 Match (lane k, entry i, src j): wakeup[k] & wakeupDstValid[k] & tag equal & !(stall & STALL_GATED_MASK[k]) & valid[i] & state WAIT/COUNT.
REQ-024 Match with latency 0 in cycle t: source counts ready combinationally in t; state READY next cycle.
REQ-025 Match with latency L>=1 in cycle t: COUNT with cnt=L-1 at t+1; cnt decrements per cycle; source ready in cycle where cnt==0 (i.e. t+L), READY afterwards.
REQ-026 Multiple matches same cycle or match while COUNT: keep minimum resulting remaining latency; spec bit = OR of spec of selected matches with equal min latency.
REQ-027 Matches against READY sources are ignored; spec bit unchanged.
REQ-028 Spec bit set when any applied match has wakeupSpec=1.
REQ-029 specConfirm (without specCancel): all spec bits cleared next cycle; states kept.
REQ-030 specCancel in cycle t: every spec source in COUNT/READY returns to WAIT, spec cleared, at t+1; in cycle t those sources and same-cycle spec matches do not count as ready; non-spec matches in t apply normally.
REQ-031 specConfirm and specCancel together: cancel wins.
REQ-032 Dispatch: entry valid=1, tags written, source state READY if dispatchedSrcReady else WAIT, spec=0, effective next cycle.
REQ-033 Dispatch overrides same-cycle wakeup, cancel and flush for that entry.
REQ-034 Two lanes same dispatchPtr: higher lane index wins.
REQ-035 flush[i]: valid[i]=0 next cycle; invalid entries never match, opReady=0.
REQ-036 opReady[i] = valid[i] & AND over j of source ready in current cycle.
REQ-037 Latency >= 2^LAT_WIDTH impossible by width; no saturation logic needed.

Reset
REQ-038 rst: all valid, spec, cnt cleared, states WAIT, tags 0; opReady=0, opSpecReady=0 in cycle after rst; rst overrides dispatch.
REQ-039 rst mid-COUNT discards the countdown; no late ready.

Verification
REQ-040 Dispatch entry 3 srcs {tag 5 not ready, tag 9 ready}; wakeup tag 5 lat 0 at t -> opReady[3]=1 at t, stays 1.
REQ-041 Wakeup tag 5 lat 3 at t -> opReady[3]=0 at t..t+2, 1 at t+3.
REQ-042 Spec wakeup tag 5 lat 0 at t, specCancel at t+2 -> opSpecReady[3]=1 at t,t+1; opReady=0 at t+2; rewakeup non-spec restores ready.
REQ-043 stall=1, tag 5 broadcast on lane 0 and lane 2 separately -> lane 0 no effect, lane 2 wakes entry.
REQ-044 Same-cycle dispatch lanes 0,1 to entry 7 with wakeup of lane-0 tag -> entry holds lane 1 data, state per dispatchedSrcReady only.
REQ-045 rst during COUNT cnt=2 -> all outputs 0 after rst, no ready pulse later.

Source files
------------

// File: rtl/source_wakeup_cam.sv
// Source-operand wakeup CAM for an issue queue: tracks per-source readiness,
// latency countdowns and load-speculation, and reports per-entry readiness.
module source_wakeup_cam #(
    parameter int unsigned ENTRY_NUM         = 16,
    parameter int unsigned SRC_OP_NUM        = 2,
    parameter int unsigned REG_NUM_BIT_WIDTH = 7,
    parameter int unsigned DISPATCH_WIDTH    = 2,
    parameter int unsigned WAKEUP_WIDTH      = 4,
    parameter int unsigned LAT_WIDTH         = 3,
    parameter logic [WAKEUP_WIDTH-1:0] STALL_GATED_MASK = 4'b0011
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         stall,
    input  logic [DISPATCH_WIDTH-1:0]                                    dispatch,
    input  logic [DISPATCH_WIDTH-1:0][$clog2(ENTRY_NUM)-1:0]             dispatchPtr,
    input  logic [DISPATCH_WIDTH-1:0][SRC_OP_NUM-1:0][REG_NUM_BIT_WIDTH-1:0] dispatchedSrcRegNum,
    input  logic [DISPATCH_WIDTH-1:0][SRC_OP_NUM-1:0]                    dispatchedSrcReady,
    input  logic [WAKEUP_WIDTH-1:0]                                      wakeup,
    input  logic [WAKEUP_WIDTH-1:0]                                      wakeupDstValid,
    input  logic [WAKEUP_WIDTH-1:0][REG_NUM_BIT_WIDTH-1:0]               wakeupDstRegNum,
    input  logic [WAKEUP_WIDTH-1:0][LAT_WIDTH-1:0]                       wakeupLatency,
    input  logic [WAKEUP_WIDTH-1:0]                                      wakeupSpec,
    input  logic                                                         specConfirm,
    input  logic                                                         specCancel,
    input  logic [ENTRY_NUM-1:0]                                         flush,
    output logic [ENTRY_NUM-1:0]                                         opReady,
    output logic [ENTRY_NUM-1:0]                                         opSpecReady
);

    typedef enum logic [1:0] {
        SRC_WAIT,
        SRC_COUNT,
        SRC_READY
    } src_state_e;

    logic [ENTRY_NUM-1:0]         valid_q, valid_d;
    logic [REG_NUM_BIT_WIDTH-1:0] tag_q   [ENTRY_NUM][SRC_OP_NUM];
    logic [REG_NUM_BIT_WIDTH-1:0] tag_d   [ENTRY_NUM][SRC_OP_NUM];
    src_state_e                   state_q [ENTRY_NUM][SRC_OP_NUM];
    src_state_e                   state_d [ENTRY_NUM][SRC_OP_NUM];
    logic [LAT_WIDTH-1:0]         cnt_q   [ENTRY_NUM][SRC_OP_NUM];
    logic [LAT_WIDTH-1:0]         cnt_d   [ENTRY_NUM][SRC_OP_NUM];
    logic                         spec_q  [ENTRY_NUM][SRC_OP_NUM];
    logic                         spec_d  [ENTRY_NUM][SRC_OP_NUM];

    logic [WAKEUP_WIDTH-1:0] lane_apply;
    logic                    spec_clear;

    // Spec broadcasts are dropped in the cycle a cancel is seen.
    assign lane_apply = wakeup & wakeupDstValid
                      & ~({WAKEUP_WIDTH{stall}} & STALL_GATED_MASK)
                      & ~({WAKEUP_WIDTH{specCancel}} & wakeupSpec);
    assign spec_clear = specConfirm & ~specCancel;

    always_comb begin
        logic                 all_ready;
        logic                 any_spec;
        logic                 cancelled;
        logic                 held_ready;
        logic                 have_cand;
        logic                 cand_spec;
        logic                 now_ready;
        logic [LAT_WIDTH-1:0] cand_lat;

        valid_d     = valid_q;
        tag_d       = tag_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        spec_d      = spec_q;
        opReady     = '0;
        opSpecReady = '0;
        all_ready   = 1'b0;
        any_spec    = 1'b0;
        cancelled   = 1'b0;
        held_ready  = 1'b0;
        have_cand   = 1'b0;
        cand_spec   = 1'b0;
        now_ready   = 1'b0;
        cand_lat    = '0;

        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            all_ready = valid_q[i];
            any_spec  = 1'b0;
            for (int unsigned j = 0; j < SRC_OP_NUM; j++) begin
                // A cancelled spec source behaves as WAIT for this cycle.
                cancelled  = specCancel & spec_q[i][j] & (state_q[i][j] != SRC_WAIT);
                held_ready = (state_q[i][j] == SRC_READY) & ~cancelled;
                have_cand  = (state_q[i][j] == SRC_COUNT) & ~cancelled;
                cand_lat   = cnt_q[i][j];
                cand_spec  = spec_q[i][j] & have_cand;

                if (valid_q[i] && !held_ready) begin
                    for (int unsigned k = 0; k < WAKEUP_WIDTH; k++) begin
                        if (lane_apply[k] && (wakeupDstRegNum[k] == tag_q[i][j])) begin
                            if (!have_cand || (wakeupLatency[k] < cand_lat)) begin
                                have_cand = 1'b1;
                                cand_lat  = wakeupLatency[k];
                                cand_spec = wakeupSpec[k];
                            end else if (wakeupLatency[k] == cand_lat) begin
                                cand_spec = cand_spec | wakeupSpec[k];
                            end
                        end
                    end
                end

                now_ready = have_cand & (cand_lat == '0);
                all_ready = all_ready & (held_ready | now_ready);
                any_spec  = any_spec | (held_ready & spec_q[i][j]) | (now_ready & cand_spec);

                if (have_cand) begin
                    state_d[i][j] = now_ready ? SRC_READY : SRC_COUNT;
                    cnt_d[i][j]   = now_ready ? '0 : cand_lat - 1'b1;
                    spec_d[i][j]  = cand_spec;
                end else if (cancelled) begin
                    state_d[i][j] = SRC_WAIT;
                    cnt_d[i][j]   = '0;
                    spec_d[i][j]  = 1'b0;
                end
                if (spec_clear) begin
                    spec_d[i][j] = 1'b0;
                end
            end
            opReady[i]     = all_ready;
            opSpecReady[i] = all_ready & any_spec;
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end
        end

        // Ascending lane order lets the higher lane win a shared pointer.
        for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
            if (dispatch[d]) begin
                valid_d[dispatchPtr[d]] = 1'b1;
                for (int unsigned j = 0; j < SRC_OP_NUM; j++) begin
                    tag_d[dispatchPtr[d]][j]   = dispatchedSrcRegNum[d][j];
                    state_d[dispatchPtr[d]][j] = dispatchedSrcReady[d][j] ? SRC_READY : SRC_WAIT;
                    cnt_d[dispatchPtr[d]][j]   = '0;
                    spec_d[dispatchPtr[d]][j]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                for (int unsigned j = 0; j < SRC_OP_NUM; j++) begin
                    tag_q[i][j]   <= '0;
                    state_q[i][j] <= SRC_WAIT;
                    cnt_q[i][j]   <= '0;
                    spec_q[i][j]  <= 1'b0;
                end
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spec_q  <= spec_d;
        end
    end

endmodule

// File: tb/tb_source_wakeup_cam.sv
// Bench for source_wakeup_cam: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an absolute-time readiness model.
module tb_source_wakeup_cam;

    localparam int E  = 16;
    localparam int S  = 2;
    localparam int RW = 7;
    localparam int D  = 2;
    localparam int W  = 4;
    localparam int LW = 3;
    localparam logic [W-1:0] GATE = 4'b0011;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0;
    logic rst, stall;
    logic [D-1:0]                 dispatch;
    logic [D-1:0][3:0]            dispatchPtr;
    logic [D-1:0][S-1:0][RW-1:0]  dispatchedSrcRegNum;
    logic [D-1:0][S-1:0]          dispatchedSrcReady;
    logic [W-1:0]                 wakeup, wakeupDstValid, wakeupSpec;
    logic [W-1:0][RW-1:0]         wakeupDstRegNum;
    logic [W-1:0][LW-1:0]         wakeupLatency;
    logic                         specConfirm, specCancel;
    logic [E-1:0]                 flush, opReady, opSpecReady;

    int checks = 0;
    int errors = 0;

    source_wakeup_cam #(
        .ENTRY_NUM(E), .SRC_OP_NUM(S), .REG_NUM_BIT_WIDTH(RW),
        .DISPATCH_WIDTH(D), .WAKEUP_WIDTH(W), .LAT_WIDTH(LW),
        .STALL_GATED_MASK(GATE)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .dispatch(dispatch), .dispatchPtr(dispatchPtr),
        .dispatchedSrcRegNum(dispatchedSrcRegNum), .dispatchedSrcReady(dispatchedSrcReady),
        .wakeup(wakeup), .wakeupDstValid(wakeupDstValid), .wakeupDstRegNum(wakeupDstRegNum),
        .wakeupLatency(wakeupLatency), .wakeupSpec(wakeupSpec),
        .specConfirm(specConfirm), .specCancel(specCancel), .flush(flush),
        .opReady(opReady), .opSpecReady(opSpecReady)
    );

    always #5 clk = ~clk;

    // Model: each source remembers the absolute cycle its value becomes usable.
    int           cyc = 0;
    bit           live = 1'b0;
    bit           m_valid [E];
    logic [RW-1:0] m_tag  [E][S];
    int           m_avail [E][S];
    bit           m_spec  [E][S];
    bit           n_valid [E];
    logic [RW-1:0] n_tag  [E][S];
    int           n_avail [E][S];
    bit           n_spec  [E][S];
    logic [E-1:0] exp_ready, exp_spec;

    function automatic void model_eval();
        for (int i = 0; i < E; i++) begin
            bit all_r = m_valid[i];
            bit any_s = 1'b0;
            n_valid[i] = m_valid[i];
            for (int j = 0; j < S; j++) begin
                int av = m_avail[i][j];
                bit sp = m_spec[i][j];
                if (specCancel && sp && av != INF) begin
                    av = INF;
                    sp = 1'b0;
                end
                if (m_valid[i] && !(av < cyc)) begin
                    for (int k = 0; k < W; k++) begin
                        if (wakeup[k] && wakeupDstValid[k] && wakeupDstRegNum[k] == m_tag[i][j]
                            && !(stall && GATE[k]) && !(specCancel && wakeupSpec[k])) begin
                            int t = cyc + int'(wakeupLatency[k]);
                            if (t < av) begin
                                av = t;
                                sp = wakeupSpec[k];
                            end else if (t == av) begin
                                sp = sp | wakeupSpec[k];
                            end
                        end
                    end
                end
                all_r = all_r && (av <= cyc);
                any_s = any_s || ((av <= cyc) && sp);
                if (specConfirm && !specCancel) sp = 1'b0;
                n_avail[i][j] = av;
                n_spec[i][j]  = sp;
                n_tag[i][j]   = m_tag[i][j];
            end
            exp_ready[i] = all_r;
            exp_spec[i]  = all_r && any_s;
            if (flush[i]) n_valid[i] = 1'b0;
        end
        for (int d = 0; d < D; d++) begin
            if (dispatch[d]) begin
                n_valid[dispatchPtr[d]] = 1'b1;
                for (int j = 0; j < S; j++) begin
                    n_tag[dispatchPtr[d]][j]   = dispatchedSrcRegNum[d][j];
                    n_avail[dispatchPtr[d]][j] = dispatchedSrcReady[d][j] ? cyc : INF;
                    n_spec[dispatchPtr[d]][j]  = 1'b0;
                end
            end
        end
    endfunction

    // Compare and advance the model at the falling edge, where inputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                model_eval();
                checks++;
                if (opReady !== exp_ready) begin
                    errors++;
                    $display("FAIL opReady cycle %0d got=%h exp=%h", cyc, opReady, exp_ready);
                end
                checks++;
                if (opSpecReady !== exp_spec) begin
                    errors++;
                    $display("FAIL opSpecReady cycle %0d got=%h exp=%h", cyc, opSpecReady, exp_spec);
                end
            end
            if (rst) begin
                live = 1'b1;
                for (int i = 0; i < E; i++) begin
                    m_valid[i] = 1'b0;
                    for (int j = 0; j < S; j++) begin
                        m_tag[i][j]   = '0;
                        m_avail[i][j] = INF;
                        m_spec[i][j]  = 1'b0;
                    end
                end
            end else if (live) begin
                m_valid = n_valid;
                m_tag   = n_tag;
                m_avail = n_avail;
                m_spec  = n_spec;
            end
            cyc++;
        end
    end

    task automatic idle();
        rst = 1'b0; stall = 1'b0; dispatch = '0; dispatchPtr = '0;
        dispatchedSrcRegNum = '0; dispatchedSrcReady = '0;
        wakeup = '0; wakeupDstValid = '0; wakeupDstRegNum = '0;
        wakeupLatency = '0; wakeupSpec = '0;
        specConfirm = 1'b0; specCancel = 1'b0; flush = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input int lane, input int ptr, input int t0, input int t1,
                        input bit r0, input bit r1);
        dispatch[lane] = 1'b1;
        dispatchPtr[lane] = 4'(ptr);
        dispatchedSrcRegNum[lane][0] = RW'(t0);
        dispatchedSrcRegNum[lane][1] = RW'(t1);
        dispatchedSrcReady[lane][0] = r0;
        dispatchedSrcReady[lane][1] = r1;
    endtask

    task automatic wake(input int lane, input int tag, input int lat, input bit sp);
        wakeup[lane] = 1'b1;
        wakeupDstValid[lane] = 1'b1;
        wakeupDstRegNum[lane] = RW'(tag);
        wakeupLatency[lane] = LW'(lat);
        wakeupSpec[lane] = sp;
    endtask

    task automatic lit(input string name, input logic [E-1:0] er, input logic [E-1:0] es);
        #2;
        checks++;
        if (opReady !== er) begin
            errors++;
            $display("FAIL %s opReady got=%h exp=%h", name, opReady, er);
        end
        checks++;
        if (opSpecReady !== es) begin
            errors++;
            $display("FAIL %s opSpecReady got=%h exp=%h", name, opSpecReady, es);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        next_cycle(); rst = 1'b1;
        next_cycle(); lit("reset", 16'h0000, 16'h0000);

        // Latency-0 wakeup
        next_cycle(); disp(0, 3, 5, 9, 0, 1); lit("pre_dispatch", 16'h0000, 16'h0000);
        next_cycle(); wake(3, 5, 0, 0);        lit("lat0_same", 16'h0008, 16'h0000);
        next_cycle();                          lit("lat0_hold", 16'h0008, 16'h0000);

        // Latency-3 wakeup
        next_cycle(); disp(0, 3, 5, 9, 0, 1); lit("redisp_a", 16'h0008, 16'h0000);
        next_cycle(); wake(3, 5, 3, 0);        lit("lat3_t0", 16'h0000, 16'h0000);
        next_cycle();                          lit("lat3_t1", 16'h0000, 16'h0000);
        next_cycle();                          lit("lat3_t2", 16'h0000, 16'h0000);
        next_cycle();                          lit("lat3_t3", 16'h0008, 16'h0000);
        next_cycle();                          lit("lat3_t4", 16'h0008, 16'h0000);

        // Spec wakeup then cancel, then non-spec re-wakeup
        next_cycle(); disp(0, 3, 5, 9, 0, 1); lit("redisp_b", 16'h0008, 16'h0000);
        next_cycle(); wake(3, 5, 0, 1);        lit("spec_t0", 16'h0008, 16'h0008);
        next_cycle();                          lit("spec_t1", 16'h0008, 16'h0008);
        next_cycle(); specCancel = 1'b1;       lit("cancel", 16'h0000, 16'h0000);
        next_cycle();                          lit("post_cancel", 16'h0000, 16'h0000);
        next_cycle(); wake(3, 5, 0, 0);        lit("rewake", 16'h0008, 16'h0000);
        next_cycle();                          lit("rewake_hold", 16'h0008, 16'h0000);

        // Spec wakeup latency 1, confirmed while counted ready
        next_cycle(); disp(0, 3, 5, 9, 0, 1); lit("redisp_c", 16'h0008, 16'h0000);
        next_cycle(); wake(3, 5, 1, 1);        lit("spec_lat1", 16'h0000, 16'h0000);
        next_cycle(); specConfirm = 1'b1;      lit("confirm", 16'h0008, 16'h0008);
        next_cycle();                          lit("post_confirm", 16'h0008, 16'h0000);

        // Stall gating: lane 0 gated, lane 2 not
        next_cycle(); disp(0, 3, 5, 9, 0, 1); lit("redisp_d", 16'h0008, 16'h0000);
        next_cycle(); stall = 1'b1; wake(0, 5, 0, 0); lit("stall_lane0", 16'h0000, 16'h0000);
        next_cycle(); stall = 1'b1; wake(2, 5, 0, 0); lit("stall_lane2", 16'h0008, 16'h0000);

        // Two dispatch lanes hit entry 7 while tags of both are broadcast
        next_cycle(); disp(0, 7, 11, 12, 0, 0); disp(1, 7, 13, 14, 1, 0);
                      wake(3, 11, 0, 0); wake(2, 14, 0, 0);
                      lit("dual_disp", 16'h0008, 16'h0000);
        next_cycle();                          lit("dual_held", 16'h0008, 16'h0000);
        next_cycle(); wake(3, 11, 0, 0);       lit("lane0_tag", 16'h0008, 16'h0000);
        next_cycle(); wake(3, 14, 0, 0);       lit("lane1_tag", 16'h0088, 16'h0000);

        // Reset in the middle of a countdown
        next_cycle(); disp(0, 5, 20, 21, 0, 1); lit("disp5", 16'h0088, 16'h0000);
        next_cycle(); wake(3, 20, 3, 0);         lit("cnt_start", 16'h0088, 16'h0000);
        next_cycle(); rst = 1'b1;                lit("cnt2_rst", 16'h0088, 16'h0000);
        next_cycle();                            lit("after_rst0", 16'h0000, 16'h0000);
        next_cycle();                            lit("after_rst1", 16'h0000, 16'h0000);
        next_cycle();                            lit("after_rst2", 16'h0000, 16'h0000);
        next_cycle();                            lit("after_rst3", 16'h0000, 16'h0000);

        // Randomized traffic over a small tag space
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            for (int d = 0; d < D; d++) begin
                dispatch[d] = ($urandom_range(0, 99) < 30);
                dispatchPtr[d] = 4'($urandom_range(0, 15));
                for (int j = 0; j < S; j++) begin
                    dispatchedSrcRegNum[d][j] = RW'($urandom_range(0, 7));
                    dispatchedSrcReady[d][j] = ($urandom_range(0, 99) < 35);
                end
            end
            for (int k = 0; k < W; k++) begin
                wakeup[k] = 1'($urandom_range(0, 1));
                wakeupDstValid[k] = ($urandom_range(0, 99) < 85);
                wakeupDstRegNum[k] = RW'($urandom_range(0, 7));
                wakeupLatency[k] = LW'($urandom_range(0, 7));
                wakeupSpec[k] = ($urandom_range(0, 99) < 25);
            end
            stall = ($urandom_range(0, 99) < 20);
            specConfirm = ($urandom_range(0, 99) < 6);
            specCancel = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 10) flush[$urandom_range(0, 15)] = 1'b1;
            rst = ($urandom_range(0, 999) < 3);
        end
        repeat (10) next_cycle();
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
